analog_sar_sequencer: RTL

//  Digital sequencer for the on-die SAR ADC behind analog pins ua[5:0]. Round-robin scans enabled

---
 rtl/analog_sar_pkg.sv | 22 ++
 rtl/rr_chan_picker.sv | 34 +++
 rtl/analog_sar_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/analog_sar_pkg.sv
// Shared state encoding and default sizing for the SAR ADC sequencer.
package analog_sar_pkg;

  localparam int DEF_NBITS         = 8;
  localparam int DEF_NCH           = 6;
  localparam int DEF_SAMPLE_CYCLES = 4;
  localparam int DEF_SETTLE_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_SETTLE,
    ST_STROBE,
    ST_DECIDE,
    ST_DONE
  } sar_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_chan_picker.sv
// Combinational round-robin pick: first enabled channel at or after ptr, wrapping modulo NCH.
module rr_chan_picker #(
  parameter int NCH = 6,
  parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] mask,
  input  logic [CW-1:0]  ptr,
  output logic [CW-1:0]  idx,
  output logic           found
);

  logic [CW-1:0]  cand [NCH];
  logic [NCH-1:0] hit;

  // cand[gi] is the channel gi positions after ptr
  for (genvar gi = 0; gi < NCH; gi++) begin : g_cand
    logic [CW:0] sum;
    assign sum       = {1'b0, ptr} + (CW+1)'(gi);
    assign cand[gi]  = (sum >= (CW+1)'(NCH)) ? CW'(sum - (CW+1)'(NCH)) : CW'(sum);
    assign hit[gi]   = mask[cand[gi]];
  end

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (hit[k]) begin
        idx   = cand[k];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/analog_sar_sequencer.sv
// Round-robin SAR conversion sequencer: tracks a channel, then binary-searches the cap-DAC code.
module analog_sar_sequencer
  import analog_sar_pkg::*;
#(
  parameter int NBITS         = DEF_NBITS,
  parameter int NCH           = DEF_NCH,
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  localparam int CW           = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  input  logic [NCH-1:0]   chan_en,
  input  logic             comp_in,
  output logic [NCH-1:0]   chan_sel,
  output logic             sample_en,
  output logic [NBITS-1:0] dac_code,
  output logic             comp_strobe,
  output logic [NBITS-1:0] result,
  output logic [CW-1:0]    result_chan,
  output logic             result_valid,
  output logic             busy
);

  localparam int BW   = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int MAXC = max2(SAMPLE_CYCLES, SETTLE_CYCLES);
  localparam int CNTW = (MAXC > 1) ? $clog2(MAXC) : 1;

  sar_state_t      state;
  logic [CNTW-1:0] cnt;
  logic [BW-1:0]   bit_idx;
  logic [CW-1:0]   ch;
  logic [CW-1:0]   ptr;

  logic [CW-1:0]    pick_idx;
  logic             pick_found;
  logic [NBITS-1:0] code_kept;
  logic [BW-1:0]    bit_dn;
  logic [CW-1:0]    ch_after;
  logic             launch;

  rr_chan_picker #(.NCH(NCH), .CW(CW)) u_picker (
    .mask  (chan_en),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Trial bit survives only if the comparator says Vin >= Vdac
  always_comb begin
    code_kept = dac_code;
    if (!comp_in) code_kept[bit_idx] = 1'b0;
  end

  assign bit_dn   = bit_idx - BW'(1);
  assign ch_after = (ch == CW'(NCH - 1)) ? '0 : ch + CW'(1);
  assign launch   = pick_found &&
                    (((state == ST_IDLE) && start) || ((state == ST_DONE) && continuous));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      ch           <= '0;
      ptr          <= '0;
      chan_sel     <= '0;
      sample_en    <= 1'b0;
      dac_code     <= '0;
      comp_strobe  <= 1'b0;
      result       <= '0;
      result_chan  <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      comp_strobe  <= 1'b0;
      if (abort || !ena) begin
        state     <= ST_IDLE;
        busy      <= 1'b0;
        chan_sel  <= '0;
        sample_en <= 1'b0;
        dac_code  <= '0;
      end else if (launch) begin
        state     <= ST_SAMPLE;
        busy      <= 1'b1;
        ch        <= pick_idx;
        chan_sel  <= NCH'(1) << pick_idx;
        sample_en <= 1'b1;
        dac_code  <= '0;
        cnt       <= CNTW'(SAMPLE_CYCLES - 1);
      end else begin
        case (state)
          ST_SAMPLE: begin
            if (cnt == '0) begin
              state     <= ST_SETTLE;
              sample_en <= 1'b0;
              bit_idx   <= BW'(NBITS - 1);
              dac_code  <= NBITS'(1) << (NBITS - 1);
              cnt       <= CNTW'(SETTLE_CYCLES - 1);
            end else begin
              cnt <= cnt - CNTW'(1);
            end
          end
          ST_SETTLE: begin
            if (cnt == '0) begin
              state       <= ST_STROBE;
              comp_strobe <= 1'b1;
            end else begin
              cnt <= cnt - CNTW'(1);
            end
          end
          ST_STROBE: state <= ST_DECIDE;
          ST_DECIDE: begin
            if (bit_idx == '0) begin
              // The result is published as DONE is entered, so an abort here suppresses it
              state        <= ST_DONE;
              dac_code     <= code_kept;
              result       <= code_kept;
              result_chan  <= ch;
              result_valid <= 1'b1;
              ptr          <= ch_after;
            end else begin
              state    <= ST_SETTLE;
              bit_idx  <= bit_dn;
              dac_code <= code_kept | (NBITS'(1) << bit_dn);
              cnt      <= CNTW'(SETTLE_CYCLES - 1);
            end
          end
          ST_DONE: begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            chan_sel  <= '0;
            sample_en <= 1'b0;
            dac_code  <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
